uart_rx: RTL and testbench
==========================

# uart_rx

Receives asynchronous serial frames (1 start bit, 8 data bits LSB first, 1 stop bit, no parity) on a single line and presents each byte as a one-cycle valid pulse. It is the receive counterpart of the team's `uart_tx` and sits between the board RX pin and byte-level consumers such as FIFOs and command parsers. It synchronises the line, rejects start-bit glitches and flags frames whose stop bit is low.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 115_200: line baud rate.
- `clk` input 1: system clock; all logic is on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset. Release is synchronous to `clk` by the system.
- `i_rx` input 1: serial line, asynchronous to `clk`, idle high.
- `o_data` output 8: last correctly received byte. Held until the next good frame.
- `o_valid` output 1: one-cycle pulse; `o_data` is valid in the same cycle.
- `o_frame_err` output 1: one-cycle pulse when a frame's stop bit is sampled low.
- `o_busy` output 1: high whenever the state is not IDLE.

## Operation
- Derived constants:
  - DIVIDER = CLK_FREQ / BAUD_RATE, using integer division.
  - HALF = DIVIDER / 2.
  - DIVIDER must be at least 4 and fit in the 16-bit bit counter; otherwise elaboration fails.
- Synchroniser: `i_rx` passes through 2 flops, both reset to 1. All decisions use the synchronised output, rx_s.
- States: IDLE, START, DATA, STOP, BREAK. Unused encodings go to IDLE.
- IDLE:
  - Counter and bit index are held at 0.
  - When rx_s = 0, go to START.
- START:
  - The counter counts up.
  - At counter = HALF-1, sample rx_s. If 0, clear the counter and go to DATA. If 1, it is a glitch: go to IDLE with no output.
- DATA:
  - At counter = DIVIDER-1, shift rx_s into the MSB of the shift register (shifting right), clear the counter and increment the bit index.
  - After the 8th sample, go to STOP.
- STOP: at counter = DIVIDER-1, sample rx_s.
  - If 1: load `o_data` from the shift register, pulse `o_valid`, go to IDLE.
  - If 0: pulse `o_frame_err`, leave `o_data` unchanged, go to BREAK.
- BREAK: wait for rx_s = 1, then go to IDLE. This keeps a held-low line (break) from producing repeated frames.
- Returning to IDLE at mid-stop-bit is intentional. It allows back-to-back frames and absorbs sender clock drift.
- There is no buffering. A byte not captured in its `o_valid` cycle is lost, and no overrun flag is raised.

## Timing
- Reset values:
  - `o_data` = 0x00; `o_valid`, `o_frame_err` and `o_busy` = 0.
  - State IDLE; counter, bit index and shift register = 0; synchroniser flops = 1.
- Reset mid-frame: all of the above apply immediately and asynchronously. The partial frame is discarded with no pulse.
- Latency from the first cycle `i_rx` is low to `o_valid`/`o_frame_err`:
  - 2 cycles (synchroniser), plus HALF, plus 9×DIVIDER, plus 1 cycle (registered output), within ±1 cycle.
  - For the default parameters this is 8249 ±1.
- `o_valid` and `o_frame_err` are never high in the same cycle. Each is high for exactly one cycle per frame.
- `o_busy` rises 1 cycle after rx_s first goes low. It falls in the same cycle that `o_valid` rises; after a frame error it falls when BREAK exits.
- Sample points are nominally at mid-bit. Frames are received correctly with a sender rate error of ±2%.

## Structure
- Shared package `uart_pkg`:
  - State encoding constants: IDLE, START, DATA, STOP, BREAK.
  - A function computing DIVIDER and HALF from CLK_FREQ and BAUD_RATE, also used by `uart_tx`.
  - Frame constants: DATA_BITS = 8, STOP_BITS = 1.
- One natural sub-module: `sync_2ff`, a 2-stage synchroniser with a reset-value parameter. It is reusable for other asynchronous inputs.

## Test plan
All scenarios use the default parameters: DIVIDER = 868, HALF = 434.
- Reset: hold `rst_n` low while toggling `i_rx` → all outputs stay 0 and `o_busy` stays 0. After release with `i_rx` = 1 → no pulses.
- Single frame 0x55 at 868 cycles/bit → exactly one `o_valid` at 8249 ±1 cycles after the start edge, with `o_data` = 0x55 and no `o_frame_err`.
- Glitch: `i_rx` low for 200 cycles, then high → no `o_valid` or `o_frame_err`, and `o_busy` falls within 437 cycles of the edge.
- Bad stop bit: frame 0xA3 with stop bit 0, then line held low for 20000 cycles → exactly one `o_frame_err` and `o_data` still 0x00. After the line goes high, frame 0x0F → `o_valid` with 0x0F.
- Back-to-back frames 0x00, 0xFF, 0x3C with one stop bit each, at ±2% bit time (851 and 885 cycles) → three `o_valid` pulses carrying those values in order.
- Reset asserted during data bit 3 of frame 0x81 → outputs clear immediately with no pulse. The next frame 0xC5 after release → `o_valid` with 0xC5.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: frame constants, receiver state encoding and baud divider helper.
package uart_pkg;

  localparam int unsigned DataBits = 8;
  localparam int unsigned StopBits = 1;

  typedef enum logic [2:0] {
    StIdle  = 3'd0,
    StStart = 3'd1,
    StData  = 3'd2,
    StStop  = 3'd3,
    StBreak = 3'd4
  } uart_state_e;

  typedef struct packed {
    logic [31:0] divider;
    logic [31:0] half;
  } baud_cfg_t;

  function automatic baud_cfg_t calc_baud(input int unsigned clk_freq,
                                          input int unsigned baud_rate);
    baud_cfg_t cfg;
    cfg.divider = clk_freq / baud_rate;
    cfg.half    = cfg.divider / 2;
    return cfg;
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchroniser for a single asynchronous input with a configurable reset value.
module sync_2ff #(
  parameter bit ResetVal = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;

  always_comb begin
    meta_d = d_i;
    sync_d = meta_q;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= ResetVal;
      sync_q <= ResetVal;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver: mid-bit sampling, start-glitch rejection, framing-error and break handling.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ  = 100_000_000,
  parameter int unsigned BAUD_RATE = 115_200
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       i_rx,
  output logic [7:0] o_data,
  output logic       o_valid,
  output logic       o_frame_err,
  output logic       o_busy
);

  localparam baud_cfg_t   Cfg     = calc_baud(CLK_FREQ, BAUD_RATE);
  localparam int unsigned Divider = Cfg.divider;
  localparam int unsigned Half    = Cfg.half;

  if (Divider < 4 || Divider > 65535) begin : gen_bad_divider
    $error("uart_rx: CLK_FREQ/BAUD_RATE must be in [4, 65535]");
  end

  localparam logic [15:0] DivLast  = 16'(Divider - 1);
  localparam logic [15:0] HalfLast = 16'(Half - 1);
  localparam logic [3:0]  LastBit  = 4'(DataBits - 1);

  logic rx_s;

  sync_2ff #(
    .ResetVal(1'b1)
  ) u_sync (
    .clk_i (clk),
    .rst_ni(rst_n),
    .d_i   (i_rx),
    .q_o   (rx_s)
  );

  uart_state_e         state_d, state_q;
  logic [15:0]         cnt_d, cnt_q;
  logic [3:0]          idx_d, idx_q;
  logic [DataBits-1:0] shift_d, shift_q;
  logic [7:0]          data_d, data_q;
  logic                valid_d, valid_q;
  logic                ferr_d, ferr_q;
  logic                busy_d, busy_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    valid_d = 1'b0;
    ferr_d  = 1'b0;

    case (state_q)
      StIdle: begin
        cnt_d = '0;
        idx_d = '0;
        if (!rx_s) state_d = StStart;
      end
      StStart: begin
        if (cnt_q == HalfLast) begin
          cnt_d   = '0;
          // A line that is high again at mid-start-bit was only a glitch.
          state_d = rx_s ? StIdle : StData;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StData: begin
        if (cnt_q == DivLast) begin
          cnt_d   = '0;
          shift_d = {rx_s, shift_q[DataBits-1:1]};
          idx_d   = idx_q + 4'd1;
          if (idx_q == LastBit) state_d = StStop;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StStop: begin
        if (cnt_q == DivLast) begin
          cnt_d = '0;
          if (rx_s) begin
            data_d  = shift_q;
            valid_d = 1'b1;
            state_d = StIdle;
          end else begin
            ferr_d  = 1'b1;
            state_d = StBreak;
          end
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      StBreak: begin
        if (rx_s) state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
        cnt_d   = '0;
        idx_d   = '0;
      end
    endcase

    busy_d = (state_d != StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      shift_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ferr_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ferr_q  <= ferr_d;
      busy_q  <= busy_d;
    end
  end

  assign o_data      = data_q;
  assign o_valid     = valid_q;
  assign o_frame_err = ferr_q;
  assign o_busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx at 100 MHz / 115200 baud (868 cycles per bit).
module tb_uart_rx;

  localparam int unsigned Div = 868;
  localparam int unsigned Lat = 8249;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       i_rx = 1'b1;
  logic [7:0] o_data;
  logic       o_valid;
  logic       o_frame_err;
  logic       o_busy;

  always #5 clk = ~clk;

  uart_rx #(
    .CLK_FREQ (100_000_000),
    .BAUD_RATE(115_200)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .i_rx       (i_rx),
    .o_data     (o_data),
    .o_valid    (o_valid),
    .o_frame_err(o_frame_err),
    .o_busy     (o_busy)
  );

  int          checks = 0;
  int          errors = 0;
  int unsigned cyc = 0;

  logic [7:0]  got_q[$];
  int unsigned got_cyc[$];
  int unsigned n_ferr = 0;
  int unsigned ferr_cyc = 0;
  int unsigned n_both = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (o_valid) begin
      got_q.push_back(o_data);
      got_cyc.push_back(cyc);
    end
    if (o_frame_err) begin
      n_ferr   <= n_ferr + 1;
      ferr_cyc <= cyc;
    end
    if (o_valid && o_frame_err) n_both <= n_both + 1;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, got, got, exp, exp);
    end
  endtask

  task automatic chk_rng(input string name, input int unsigned got, input int unsigned lo,
                         input int unsigned hi);
    checks++;
    if (got < lo || got > hi) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d..%0d", name, got, lo, hi);
    end
  endtask

  // Called right after a posedge; each bit lasts exactly bc cycles.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int unsigned bc,
                            output int unsigned sc);
    #1;
    sc   = cyc;
    i_rx = 1'b0;
    repeat (bc) @(posedge clk);
    for (int i = 0; i < 8; i++) begin
      #1;
      i_rx = d[i];
      repeat (bc) @(posedge clk);
    end
    #1;
    i_rx = stop;
    repeat (bc) @(posedge clk);
  endtask

  typedef struct {
    logic [7:0]  data;
    int unsigned bit_cyc;
    logic [7:0]  exp_data;
    int unsigned exp_lat;
  } vec_t;

  vec_t        vecs[5];
  int unsigned starts[5];
  int unsigned sc;
  int unsigned base_v;
  int unsigned base_e;
  int unsigned bad;
  int unsigned fall;
  logic        seen;

  initial begin
    vecs[0] = '{data: 8'h0F, bit_cyc: 868, exp_data: 8'h0F, exp_lat: 8249};
    vecs[1] = '{data: 8'h55, bit_cyc: 868, exp_data: 8'h55, exp_lat: 8249};
    vecs[2] = '{data: 8'h00, bit_cyc: 851, exp_data: 8'h00, exp_lat: 8249};
    vecs[3] = '{data: 8'hFF, bit_cyc: 885, exp_data: 8'hFF, exp_lat: 8249};
    vecs[4] = '{data: 8'h3C, bit_cyc: 851, exp_data: 8'h3C, exp_lat: 8249};

    // Reset held while the line toggles.
    bad = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      i_rx = (i % 3 == 0) ? 1'b0 : 1'b1;
      if (o_valid || o_frame_err || o_busy || o_data != 8'h00) bad++;
    end
    chk("reset_quiet", bad, 0);
    chk("reset_data", o_data, 8'h00);
    chk("reset_busy", o_busy, 1'b0);
    i_rx = 1'b1;
    @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (100) @(posedge clk);
    @(negedge clk);
    chk("post_reset_valid", got_q.size(), 0);
    chk("post_reset_ferr", n_ferr, 0);
    chk("post_reset_busy", o_busy, 1'b0);
    @(posedge clk);

    // Start-bit glitch of 200 cycles.
    base_v = got_q.size();
    base_e = n_ferr;
    #1;
    sc   = cyc;
    i_rx = 1'b0;
    repeat (200) @(posedge clk);
    #1 i_rx = 1'b1;
    seen = 1'b0;
    fall = 0;
    for (int k = 0; k < 600; k++) begin
      @(negedge clk);
      if (o_busy) seen = 1'b1;
      else if (seen && fall == 0) fall = cyc - sc;
    end
    chk("glitch_busy_seen", seen, 1'b1);
    chk_rng("glitch_busy_fall", fall, 1, 437);
    chk("glitch_no_valid", got_q.size(), base_v);
    chk("glitch_no_ferr", n_ferr, base_e);
    @(posedge clk);

    // Bad stop bit then a 20000-cycle break.
    send_frame(8'hA3, 1'b0, Div, sc);
    repeat (20000) @(posedge clk);
    @(negedge clk);
    chk("break_one_ferr", n_ferr, base_e + 1);
    chk_rng("break_ferr_latency", ferr_cyc - sc, Lat - 1, Lat + 1);
    chk("break_no_valid", got_q.size(), base_v);
    chk("break_data_kept", o_data, 8'h00);
    chk("break_busy_held", o_busy, 1'b1);
    @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (10) @(posedge clk);
    @(negedge clk);
    chk("break_exit_busy", o_busy, 1'b0);
    @(posedge clk);

    // Table: 0x0F and 0x55 nominal, then back-to-back at +/-2% bit time.
    base_v = got_q.size();
    base_e = n_ferr;
    for (int i = 0; i < 5; i++) send_frame(vecs[i].data, 1'b1, vecs[i].bit_cyc, starts[i]);
    repeat (50) @(posedge clk);
    @(negedge clk);
    chk("table_count", got_q.size(), base_v + 5);
    for (int i = 0; i < 5; i++) begin
      if (got_q.size() > base_v + i) begin
        chk($sformatf("table_data_%0d", i), got_q[base_v+i], vecs[i].exp_data);
        chk_rng($sformatf("table_lat_%0d", i), got_cyc[base_v+i] - starts[i],
                vecs[i].exp_lat - 1, vecs[i].exp_lat + 1);
      end
    end
    chk("table_no_ferr", n_ferr, base_e);
    chk("table_hold_data", o_data, 8'h3C);
    chk("table_idle_busy", o_busy, 1'b0);
    @(posedge clk);

    // Reset during data bit 3 of 0x81.
    base_v = got_q.size();
    base_e = n_ferr;
    #1 i_rx = 1'b0;
    repeat (Div) @(posedge clk);
    #1 i_rx = 1'b1;
    repeat (Div) @(posedge clk);
    #1 i_rx = 1'b0;
    repeat (2 * Div + 400) @(posedge clk);
    @(negedge clk);
    chk("midreset_busy_before", o_busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk("midreset_busy", o_busy, 1'b0);
    chk("midreset_valid", o_valid, 1'b0);
    chk("midreset_ferr", o_frame_err, 1'b0);
    chk("midreset_data", o_data, 8'h00);
    i_rx = 1'b1;
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("midreset_no_valid", got_q.size(), base_v);
    chk("midreset_no_ferr", n_ferr, base_e);
    @(posedge clk);
    send_frame(8'hC5, 1'b1, Div, sc);
    repeat (20) @(posedge clk);
    @(negedge clk);
    chk("after_reset_count", got_q.size(), base_v + 1);
    if (got_q.size() > base_v) begin
      chk("after_reset_data", got_q[base_v], 8'hC5);
      chk_rng("after_reset_lat", got_cyc[base_v] - sc, Lat - 1, Lat + 1);
    end
    chk("never_both", n_both, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
